// File: rtl/elem_packer.sv
// elem_packer: gathers ELEM_WIDTH-bit elements into a NUM_ELEMS-slot packed
// word. A word closes when its last slot fills or when i_last arrives. Slots
// that were never written are zero, and the output reports how many slots
// were filled. The output register holds its word until downstream takes it.
module elem_packer #(
    parameter int ELEM_WIDTH = 10,
    parameter int NUM_ELEMS  = 10,
    parameter int CNT_WIDTH  = $clog2(NUM_ELEMS + 1)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [ELEM_WIDTH-1:0]            i_data,
    input  logic                             i_last,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [NUM_ELEMS*ELEM_WIDTH-1:0]  o_data,
    output logic [CNT_WIDTH-1:0]             o_count,
    output logic                             o_last
);

    localparam int WORD_WIDTH = NUM_ELEMS * ELEM_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_ELEMS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0]  idx_q, idx_d;
    logic [WORD_WIDTH-1:0] asm_q, asm_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  last_q, last_d;
    logic                  valid_q, valid_d;

    logic [WORD_WIDTH-1:0] merged;
    logic                  accept;
    logic                  closing;
    logic                  transfer;

    // A held (not yet taken) output word blocks every new element, closing
    // or not, so the assembly buffer can never need a second output slot.
    assign o_ready  = !(valid_q && !i_ready);
    assign accept   = i_valid && o_ready;
    assign closing  = accept && ((idx_q == LAST_IDX) || i_last);
    assign transfer = valid_q && i_ready;

    // Assembly buffer with the incoming element dropped into slot idx.
    // Slots above idx are forced to zero so an early close pads cleanly.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ELEMS; gi++) begin : g_slot
            assign merged[gi*ELEM_WIDTH +: ELEM_WIDTH] =
                (idx_q == CNT_WIDTH'(gi))  ? i_data :
                (CNT_WIDTH'(gi) < idx_q)   ? asm_q[gi*ELEM_WIDTH +: ELEM_WIDTH] :
                                             '0;
        end
    endgenerate

    // Next-state: fill the buffer, close into the output register, retire on handshake.
    always_comb begin
        idx_d   = idx_q;
        asm_d   = asm_q;
        data_d  = data_q;
        count_d = count_q;
        last_d  = last_q;
        valid_d = valid_q;

        if (transfer) begin
            valid_d = 1'b0;
        end

        // A close on the same edge as a transfer reloads the register, so
        // valid stays high and the stream runs without bubbles.
        if (accept) begin
            if (closing) begin
                data_d  = merged;
                count_d = idx_q + CNT_ONE;
                last_d  = i_last;
                valid_d = 1'b1;
                idx_d   = '0;
                asm_d   = '0;
            end else begin
                asm_d   = merged;
                idx_d   = idx_q + CNT_ONE;
            end
        end
    end

    // State registers; reset drops any partial word and clears the output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx_q   <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            count_q <= count_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_count = count_q;
    assign o_last  = last_q;

endmodule

// File: tb/tb_elem_packer.sv
// tb_elem_packer: directed scenarios plus random traffic for elem_packer,
// checked every cycle against a queue-based model of the packing rules.
module tb_elem_packer;

    localparam int W    = 10;
    localparam int N    = 10;
    localparam int CW   = $clog2(N + 1);
    localparam int WORD = N * W;

    logic            clk;
    logic            rst;
    logic            i_valid;
    logic            o_ready;
    logic [W-1:0]    i_data;
    logic            i_last;
    logic            o_valid;
    logic            i_ready;
    logic [WORD-1:0] o_data;
    logic [CW-1:0]   o_count;
    logic            o_last;

    elem_packer #(
        .ELEM_WIDTH (W),
        .NUM_ELEMS  (N)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_count (o_count),
        .o_last  (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: elements of the word being built, plus the word
    // currently offered downstream.
    logic [W-1:0]    part[$];
    logic            m_valid = 1'b0;
    logic [WORD-1:0] m_data  = '0;
    int              m_count = 0;
    logic            m_last  = 1'b0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive inputs just after the falling edge, check
    // ready, advance the model by the same rules, then check outputs at the
    // next falling edge.
    task automatic do_cycle(input logic v, input logic [W-1:0] d, input logic l, input logic r);
        logic            exp_ready;
        logic            acc;
        logic [WORD-1:0] w;
        i_valid = v;
        i_data  = d;
        i_last  = l;
        i_ready = r;
        #1;
        exp_ready = !(m_valid && !r);
        check_val("o_ready", 128'(o_ready), 128'(exp_ready));
        acc = v && exp_ready;
        if (m_valid && r) m_valid = 1'b0;
        if (acc) begin
            part.push_back(d);
            if (l || part.size() == N) begin
                w = '0;
                foreach (part[i]) w[i*W +: W] = part[i];
                m_data  = w;
                m_count = part.size();
                m_last  = l;
                m_valid = 1'b1;
                part.delete();
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_val("o_valid", 128'(o_valid), 128'(m_valid));
        if (m_valid) begin
            check_val("o_data",  128'(o_data),  128'(m_data));
            check_val("o_count", 128'(o_count), 128'(m_count));
            check_val("o_last",  128'(o_last),  128'(m_last));
        end
    endtask

    initial begin
        logic [W-1:0] seq2 [3];
        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_last  = 1'b0;
        i_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_o_valid", 128'(o_valid), 128'(0));
        check_val("rst_o_data",  128'(o_data),  128'(0));
        check_val("rst_o_count", 128'(o_count), 128'(0));
        check_val("rst_o_last",  128'(o_last),  128'(0));
        check_val("rst_o_ready", 128'(o_ready), 128'(1));
        @(negedge clk);

        // Full word of 1..10, then one idle cycle so valid is seen to drop.
        for (int k = 0; k < N; k++) do_cycle(1'b1, W'(k + 1), 1'b0, 1'b1);
        do_cycle(1'b0, '0, 1'b0, 1'b1);

        // Early close after three elements, then a word that must start at slot 0.
        seq2[0] = 10'h3FF; seq2[1] = 10'h155; seq2[2] = 10'h2AA;
        for (int k = 0; k < 3; k++) do_cycle(1'b1, seq2[k], (k == 2), 1'b1);
        for (int k = 0; k < N; k++) do_cycle(1'b1, W'(100 + k), 1'b0, 1'b1);
        do_cycle(1'b0, '0, 1'b0, 1'b1);

        // Backpressure: full word held while the producer keeps offering 0x7.
        for (int k = 0; k < N; k++) do_cycle(1'b1, W'(200 + k), 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) do_cycle(1'b1, W'(7), 1'b0, 1'b0);
        do_cycle(1'b1, W'(7), 1'b0, 1'b1);
        for (int k = 0; k < N - 1; k++) do_cycle(1'b1, W'(300 + k), 1'b0, 1'b1);
        do_cycle(1'b0, '0, 1'b0, 1'b1);

        // Back-to-back stream 0..29.
        for (int k = 0; k < 30; k++) do_cycle(1'b1, W'(k), 1'b0, 1'b1);
        do_cycle(1'b0, '0, 1'b0, 1'b1);

        // Single-element words.
        for (int k = 0; k < 3; k++) do_cycle(1'b1, W'(5 + k), 1'b1, 1'b1);
        do_cycle(1'b0, '0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a cycle, four elements in.
        for (int k = 0; k < 4; k++) do_cycle(1'b1, W'(400 + k), 1'b0, 1'b1);
        i_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_val("arst_o_valid", 128'(o_valid), 128'(0));
        check_val("arst_o_data",  128'(o_data),  128'(0));
        check_val("arst_o_count", 128'(o_count), 128'(0));
        #1 rst = 1'b0;
        part.delete();
        m_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) do_cycle(1'b1, W'(500 + k), 1'b0, 1'b1);
        do_cycle(1'b0, '0, 1'b0, 1'b1);

        // Random traffic with random early closes and backpressure.
        for (int k = 0; k < 400; k++) begin
            do_cycle($urandom_range(0, 3) != 0,
                     W'($urandom),
                     $urandom_range(0, 7) == 0,
                     $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
